reg_write_arbiter: RTL and testbench
====================================

# reg_write_arbiter

Round-robin write arbiter that shares one 8-bit `register` instance between up to NREQ requesters, such as the microcode sequencer, the UART receive path and the front-panel loader. The arbiter samples the requests and registers the winner's data. It then drives the register's active-low write enable for exactly one cycle and acknowledges the winner. It sits between the requesters and the `register` instance and is the only block permitted to drive that register's WE and data inputs.

## Interface
Parameters:
- WordSize, 8, width of the data path and of the shared register.
- NREQ, 4, number of requesters; legal range 2..8.
- IDW, clog2(NREQ), width of the grant index.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- req  in  NREQ  bit i high means requester i wants one write; held high until ack[i] is seen.
- req_data  in  NREQ*WordSize  flattened data; slice i is bits [i*WordSize +: WordSize].
- ack  out  NREQ  one-hot, single-cycle pulse; asserted in the cycle requester i's write is presented.
- reg_we_n  out  1  to register WE; active low, low for exactly one cycle per grant.
- reg_data  out  WordSize  to register data input.
- gnt_id  out  IDW  index of the current or most recent winner.
- busy  out  1  high in any cycle where reg_we_n is low.

## Operation
- Arbitration runs every cycle on the masked request vector, `req & ~ack`.
- A requester whose ack is high this cycle is excluded from the arbitration at the next edge. The requester drops req in the cycle after its ack, and this masking stops a stale req from being granted twice.
- Priority is round-robin from pointer `ptr`. The winner is the first set bit of the masked vector at or after ptr, searching upward with wrap-around from NREQ-1 to 0.
- When a winner w exists at an edge, the arbiter registers:
  - reg_data ← req_data[w]
  - reg_we_n ← 0
  - ack ← one-hot(w)
  - gnt_id ← w
  - ptr ← (w+1) mod NREQ, wrapping from NREQ-1 to 0
- When no winner exists at an edge: reg_we_n ← 1 and ack ← 0. reg_data, gnt_id and ptr hold their values.
- The arbiter has no FSM beyond ptr and the registered outputs. It never stalls; it can issue one write per cycle when different requesters alternate.
- A single requester that holds req continuously is granted every other cycle. The ack mask forces this.
- Reset (rst_n low at an edge) applies even in the middle of a grant:
  - ptr=0, reg_we_n=1, ack=0, gnt_id=0, reg_data=0, busy=0.
  - A grant in flight when reset is sampled is cancelled. Its ack does not appear, and the requester must re-request.
- A req deasserted before ack arrives is a protocol violation, not a supported mode. If the withdrawn request has already been sampled, its write still completes.

## Timing
- Request latency: req[i] high before edge E, and i wins → ack[i], reg_we_n=0 and reg_data valid in cycle E..E+1.
- The register captures the data at edge E+1, and the new value is visible at the register output after E+1.
- Minimum latency is 1 cycle. Worst case with all NREQ requesting is NREQ cycles.
- req_data[i] must be stable from the assertion of req[i] until the edge at which ack[i] goes high.
- Simultaneous requests resolve by ptr order only. Request arrival order is not tracked.
- busy equals ~reg_we_n and is registered, with no combinational path from req.

## Structure
- Shared package/header holds:
  - WordSize and NREQ defaults.
  - A clog2 function for IDW.
  - The one-hot constant helper.
- Sub-module `rr_pick`: purely combinational.
  - Inputs: masked request vector and ptr. Outputs: valid and winner index.
  - Implement it as a doubled-vector priority search.
- reg_write_arbiter instantiates rr_pick and holds all flops. The `register` instance stays outside the arbiter, in the parent.

## Test plan
- Single request: reset, then req=4'b0010 with data 8'hA5 → ack=4'b0010 and reg_we_n=0 one cycle later; register reads 8'hA5 on the following cycle; ptr=2.
- All requesting: req=4'b1111 held, with distinct data 8'h10..8'h13 → grants in order 0,1,2,3,0,…; reg_we_n low every cycle after the first; each ack is exactly one cycle.
- Sole requester held: req=4'b1000 held for 6 cycles → ack[3] on alternate cycles only, giving 3 writes.
- Wrap-around fairness: ptr=3 with req=4'b1001 → winner 3, then 0.
- Mid-grant reset: rst_n low at the edge where reg_we_n would go low with data 8'h5A → outputs match reset values, no ack, and the register keeps its prior value.
- Idle hold: after a write of 8'h3C, hold req=0 for 5 cycles → reg_we_n stays 1, and reg_data and gnt_id are unchanged.

Source files
------------

// File: rtl/reg_write_arbiter_pkg.sv
// Shared defaults and helpers for the round-robin register write arbiter.
// Users import this package with: import reg_write_arbiter_pkg::*;
package reg_write_arbiter_pkg;

    localparam int WORD_SIZE_DEF = 8;
    localparam int NREQ_DEF      = 4;
    localparam int MAX_NREQ      = 8;

    // Index width for a given count. Never narrower than one bit.
    function automatic int clog2(input int value);
        int width;
        width = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << width) < value) begin
                width = width + 1;
            end else begin
                width = width;
            end
        end
        return (width < 1) ? 1 : width;
    endfunction

    function automatic logic [MAX_NREQ-1:0] one_hot(input int idx);
        logic [MAX_NREQ-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// Combinational round-robin picker.
// It finds the first set request at or after ptr, wrapping from NREQ-1 back to 0.
module rr_pick
    import reg_write_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_masked,
    input  logic [IDW-1:0]  ptr,
    output logic            valid,
    output logic [IDW-1:0]  winner
);

    logic [2*NREQ-1:0] doubled_s;
    logic [NREQ-1:0]   rotated_s;

    // Shifting the doubled vector down by ptr rotates it, so bit 0 holds the ptr slot.
    assign doubled_s = {req_masked, req_masked};
    assign rotated_s = NREQ'(doubled_s >> ptr);

    // Scan downward so that the lowest rotated offset (nearest to ptr) is written last and wins.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            winner = rotated_s[k] ? IDW'((int'(ptr) + k) % NREQ) : winner;
            valid  = valid | rotated_s[k];
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter for one shared register.
// It registers the winner's data, pulses reg_we_n low for one cycle and acks the winner.
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int WordSize = WORD_SIZE_DEF,
    parameter int NREQ     = NREQ_DEF,
    parameter int IDW      = clog2(NREQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*WordSize-1:0] req_data,
    output logic [NREQ-1:0]          ack,
    output logic                     reg_we_n,
    output logic [WordSize-1:0]      reg_data,
    output logic [IDW-1:0]           gnt_id,
    output logic                     busy
);

    logic [NREQ-1:0]     masked_s;
    logic                pick_valid_s;
    logic [IDW-1:0]      pick_idx_s;
    logic [IDW-1:0]      ptr_r;
    logic [IDW-1:0]      ptr_next_s;
    logic [NREQ-1:0]     win_ack_s;
    logic [WordSize-1:0] win_data_s;

    // A requester acked this cycle still shows req; masking it stops a second grant.
    assign masked_s   = req & ~ack;
    assign win_data_s = req_data[int'(pick_idx_s) * WordSize +: WordSize];
    assign win_ack_s  = NREQ'(one_hot(int'(pick_idx_s)));
    assign ptr_next_s = (pick_idx_s == IDW'(NREQ - 1)) ? '0 : pick_idx_s + 1'b1;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_pick (
        .req_masked (masked_s),
        .ptr        (ptr_r),
        .valid      (pick_valid_s),
        .winner     (pick_idx_s)
    );

    // Grant register: all arbiter state, with reset cancelling any grant in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_r    <= '0;
            reg_we_n <= 1'b1;
            ack      <= '0;
            gnt_id   <= '0;
            reg_data <= '0;
            busy     <= 1'b0;
        end else if (pick_valid_s) begin
            ptr_r    <= ptr_next_s;
            reg_we_n <= 1'b0;
            ack      <= win_ack_s;
            gnt_id   <= pick_idx_s;
            reg_data <= win_data_s;
            busy     <= 1'b1;
        end else begin
            reg_we_n <= 1'b1;
            ack      <= '0;
            busy     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed testbench for reg_write_arbiter.
// A behavioural model of the shared register sits on the arbiter's outputs.
module tb_reg_write_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic        reg_we_n;
    logic [7:0]  reg_data;
    logic [1:0]  gnt_id;
    logic        busy;
    logic [7:0]  reg_q = 8'h00;

    int total = 0;
    int fails = 0;
    int ack3_count;

    always #5 clk = ~clk;

    // Shared register in the parent: it captures reg_data while WE is low.
    always @(posedge clk) begin
        if (!reg_we_n) reg_q <= reg_data;
    end

    reg_write_arbiter #(.WordSize(8), .NREQ(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_data (req_data),
        .ack      (ack),
        .reg_we_n (reg_we_n),
        .reg_data (reg_data),
        .gnt_id   (gnt_id),
        .busy     (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_grant(input string tag, input logic [3:0] exp_ack,
                               input logic [1:0] exp_id, input logic [7:0] exp_data);
        check({tag, "_ack"}, 32'(ack), 32'(exp_ack));
        check({tag, "_we_n"}, 32'(reg_we_n), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_id"}, 32'(gnt_id), 32'(exp_id));
        check({tag, "_data"}, 32'(reg_data), 32'(exp_data));
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ack"}, 32'(ack), 32'd0);
        check({tag, "_we_n"}, 32'(reg_we_n), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_id"}, 32'(gnt_id), 32'd0);
        check({tag, "_data"}, 32'(reg_data), 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        req      = 4'b0000;
        req_data = 32'h0000_0000;
        step();
        step();
        check_reset("reset");

        // Single request from requester 1
        rst_n    = 1'b1;
        req      = 4'b0010;
        req_data = 32'h0000_A500;
        step();
        check_grant("single", 4'b0010, 2'd1, 8'hA5);
        req = 4'b0000;
        step();
        check("single_idle_we_n", 32'(reg_we_n), 32'd1);
        check("single_idle_ack", 32'(ack), 32'd0);
        check("single_reg", 32'(reg_q), 32'hA5);

        // The pointer now sits at 2: requesters 1 and 2 together give 2 first, then 1.
        req      = 4'b0110;
        req_data = 32'h0022_1100;
        step();
        check_grant("ptr2_first", 4'b0100, 2'd2, 8'h22);
        req = 4'b0010;
        step();
        check_grant("ptr2_second", 4'b0010, 2'd1, 8'h11);
        req = 4'b0000;
        step();
        check("ptr2_reg", 32'(reg_q), 32'h11);

        // All four requesting with a fresh pointer
        rst_n = 1'b0;
        step();
        rst_n    = 1'b1;
        req      = 4'b1111;
        req_data = 32'h1312_1110;
        for (int k = 0; k < 6; k++) begin
            step();
            check_grant($sformatf("all_%0d", k), 4'(1 << (k % 4)), 2'(k % 4), 8'(8'h10 + k % 4));
        end
        req = 4'b0000;
        step();
        check("all_end_we_n", 32'(reg_we_n), 32'd1);
        check("all_end_reg", 32'(reg_q), 32'h11);

        // A single requester holding req is granted only on alternate cycles.
        req        = 4'b1000;
        req_data   = 32'h7700_0000;
        ack3_count = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            check($sformatf("sole_ack_%0d", k), 32'(ack), (k % 2 == 0) ? 32'h8 : 32'h0);
            check($sformatf("sole_we_n_%0d", k), 32'(reg_we_n), (k % 2 == 0) ? 32'd0 : 32'd1);
            if (ack[3]) ack3_count++;
        end
        check("sole_writes", 32'(ack3_count), 32'd3);
        req = 4'b0000;
        step();

        // Wrap-around: a grant to 2 leaves the pointer at 3, so 1001 serves 3 then 0.
        req      = 4'b0100;
        req_data = 32'h3355_6644;
        step();
        check_grant("wrap_setup", 4'b0100, 2'd2, 8'h55);
        req = 4'b1001;
        step();
        check_grant("wrap_first", 4'b1000, 2'd3, 8'h33);
        req = 4'b0001;
        step();
        check_grant("wrap_second", 4'b0001, 2'd0, 8'h44);
        req = 4'b0000;
        step();
        check("wrap_reg", 32'(reg_q), 32'h44);

        // Reset lands on the edge that would have issued the grant.
        req      = 4'b0100;
        req_data = 32'h005A_0000;
        rst_n    = 1'b0;
        step();
        check_reset("midreset");
        req = 4'b0000;
        step();
        check("midreset_reg", 32'(reg_q), 32'h44);
        rst_n = 1'b1;

        // Idle hold after a write of 8'h3C by requester 2
        req      = 4'b0100;
        req_data = 32'h003C_0000;
        step();
        check_grant("hold_write", 4'b0100, 2'd2, 8'h3C);
        req      = 4'b0000;
        req_data = 32'hFFFF_FFFF;
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("hold_we_n_%0d", k), 32'(reg_we_n), 32'd1);
            check($sformatf("hold_data_%0d", k), 32'(reg_data), 32'h3C);
            check($sformatf("hold_id_%0d", k), 32'(gnt_id), 32'd2);
            check($sformatf("hold_ack_%0d", k), 32'(ack), 32'd0);
        end
        check("hold_reg", 32'(reg_q), 32'h3C);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
